// File: rtl/pipeline_out_fifo.sv
// pipeline_out_fifo
//
// Output buffer for a fixed-latency arithmetic pipeline that cannot be stalled.
// Every result strobe is captured into a circular FIFO and offered to the consumer
// with a ready/valid handshake. A result that arrives while the FIFO is full, and
// no slot frees up on the same edge, is dropped. Each drop sets a sticky flag and
// increments a saturating counter.
//
// Ports
//   clk        single clock, rising-edge
//   rst_n      synchronous active-low reset
//   in_valid   result strobe from upstream
//   in_data    signed result from upstream (W bits)
//   out_valid  head entry available
//   out_ready  consumer accepts head entry
//   out_data   head entry, first-word-fall-through (W bits)
//   count      entries held, 0..DEPTH (AW+1 bits)
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky: a sample was dropped since reset/clear
//   drop_cnt   dropped-sample counter, saturates at 255
//   clr_ovf    clears overflow and drop_cnt (a same-cycle drop wins)

module pipeline_out_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic [7:0]    drop_cnt,
  input  logic          clr_ovf
);

  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

  // State
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  // Handshake decode
  logic push;
  logic pop;
  logic drop;

  // Flags come from registered occupancy only, so there is no path from in_valid
  // or out_ready to any flag.
  always_comb begin
    full      = (count_q == DepthCnt);
    empty     = (count_q == '0);
    out_valid = !empty;
    count     = count_q;
    overflow  = overflow_q;
    drop_cnt  = drop_cnt_q;
    out_data  = mem_q[rp_q];
  end

  // A full FIFO still accepts a sample when the head is popped on the same edge.
  always_comb begin
    pop  = out_valid && out_ready;
    push = in_valid && (!full || pop);
    drop = in_valid && full && !pop;
  end

  // Storage and pointers
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (push) begin
      mem_d[wp_q] = in_data;
      wp_d        = wp_q + AW'(1);
    end
    if (pop) begin
      rp_d = rp_q + AW'(1);
    end
  end

  // Occupancy
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Drop bookkeeping. A drop in the same cycle as a clear restarts the count at 1.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_ovf) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  // Memory is cleared on reset so out_data is never X.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: doc/pipeline_out_fifo.md
# pipeline_out_fifo

Output buffer that sits directly downstream of the fixed-latency arithmetic pipeline. It captures every `Y`/`out_valid` result, which that pipeline produces with no backpressure, into a small circular FIFO. It presents the results to the consumer through a ready/valid handshake. Results that arrive while the FIFO is full are dropped, counted, and flagged, never silently lost.

## Interface
- `W`, 16: sample width; signed two's complement data.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `AW`, $clog2(DEPTH): pointer width (derived; not overridden).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  result strobe from upstream pipeline (its `out_valid`).
- `in_data`  in  W  signed result from upstream pipeline (its `Y`).
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head entry.
- `out_data`  out  W  signed head entry.
- `count`  out  AW+1  entries held, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: at least one sample dropped since reset/clear.
- `drop_cnt`  out  8  dropped-sample counter, saturates at 255.
- `clr_ovf`  in  1  clears `overflow` and `drop_cnt`.

## Operation
- Storage: `DEPTH`×`W` register array, write pointer `wp`, read pointer `rp` (both AW bits, wrap modulo DEPTH), occupancy `count` (AW+1 bits).
- push = `in_valid && (!full || pop)`; pop = `out_valid && out_ready`.
- push: `mem[wp] <= in_data`, `wp <= wp+1`.
- pop: `rp <= rp+1`.
- `count` changes by +1 on push only, −1 on pop only, and does not change on both or neither.
- Drop: `in_valid && full && !pop` drops the sample. `mem`, `wp`, and `count` are untouched. `overflow <= 1`, and `drop_cnt <= drop_cnt+1` unless it is already 255.
- Full with simultaneous pop: the sample is accepted (slot freed same edge); no drop.
- Empty: `out_valid` is 0, so no pop is possible. A push in the same cycle is not visible until the next cycle (no bypass).
- `out_data = mem[rp]` (first-word-fall-through). Its value is don't-care when `out_valid = 0`, but it must not be X after reset, so `mem` is cleared by reset.
- `out_valid = !empty`; `full`/`empty` are decoded from `count`.
- Data is passed bit-exact: no resizing, rounding, or sign change.
- `clr_ovf`: `overflow <= 0`, `drop_cnt <= 0`.
  - If a drop occurs in the same cycle, the drop wins: `overflow <= 1`, `drop_cnt <= 1`.
  - `clr_ovf` does not affect FIFO contents.
- `out_ready` while `out_valid = 0` is ignored.
- The consumer may hold `out_ready` high indefinitely, giving one pop per cycle while non-empty.

## Timing
- Reset (`rst_n = 0` at a rising edge) sets:
  - `wp = rp = 0`, `count = 0`, `empty = 1`, `full = 0`, `out_valid = 0`;
  - `out_data = 0`, `overflow = 0`, `drop_cnt = 0`, all `mem` entries 0.
- Reset takes priority over push/pop/clear in the same cycle.
- Reset mid-operation discards all held entries. The first `in_valid` sampled with `rst_n = 1` is accepted normally.
- Write latency: a sample pushed at edge N is visible on `out_data` with `out_valid = 1` after edge N when the FIFO was empty. Otherwise it appears after all older entries are popped.
- Throughput: one push and one pop per cycle sustained. Ordering is strict FIFO.
- `count`, `full`, `empty`, `out_valid` update only at clock edges. There is no combinational path from `in_valid` to `out_valid`.
- The only combinational paths to outputs are `rp`→`out_data` (through the memory read) and registered state→flags. Nothing passes from `out_ready` to any output.

## Test plan
- Reset/idle: hold `rst_n = 0` for 2 cycles with `in_valid = 1`, `in_data = 5` → all outputs 0, `empty = 1`, `count = 0`.
- Ordered flow: push 20, −3, 7 on consecutive cycles with `out_ready = 0`, then raise `out_ready` → `count = 3`; `out_data` yields 20, −3, 7 on three consecutive edges; then `empty = 1`.
- Fill and overflow (DEPTH = 8): push 1..10 with `out_ready = 0` →
  - `full = 1` after the 8th push;
  - samples 9 and 10 dropped, `overflow = 1`, `drop_cnt = 2`;
  - drain yields exactly 1..8.
- Full with simultaneous pop: fill with 1..8, then on one edge push 99 with `out_ready = 1` → no drop, `count` stays 8, and the drained sequence is 2..8, 99.
- Pointer wrap: 3× (push 5 samples, pop 5) with `DEPTH = 8` → data intact across wrap, `count` returns to 0 each time.
- Clear/saturation: force 300 drops → `drop_cnt = 255`. Then `clr_ovf` with no drop → 0/0. Then `clr_ovf` together with a drop → `overflow = 1`, `drop_cnt = 1`.
- Reset mid-run: with 4 entries held, pulse `rst_n = 0` for 1 cycle, then push 42 → `count = 1` and `out_data = 42`.
